// File: rtl/cross_bar_slave_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cross_bar_slave_arbiter_pkg
// Shared crossbar geometry, bus types and the per-slave arbiter state type.
// Every crossbar file imports this package.
//   MASTER_N / MASTER_W : number of masters and the width of a master index
//   SLAVE_N  / SLAVE_W  : number of slaves and the width of the slave-select
//                         field (the top SLAVE_W address bits)
//   addr_t / data_t     : address and data words
//   arb_state_t         : slave arbiter FSM states
// ---------------------------------------------------------------------------
package cross_bar_slave_arbiter_pkg;

    localparam int MASTER_N = 4;
    localparam int SLAVE_N  = 4;
    localparam int MASTER_W = 2;
    localparam int SLAVE_W  = 2;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [MASTER_W-1:0] midx_t;
    typedef logic [SLAVE_W-1:0]  sidx_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SREQ = 2'd1,
        ARB_MACK = 2'd2
    } arb_state_t;

    // One-hot master mask for a master index.
    function automatic logic [MASTER_N-1:0] onehot(input midx_t idx);
        logic [MASTER_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Slave-select field of an address.
    function automatic sidx_t slave_sel(input addr_t a);
        return a[ADDR_W-1 -: SLAVE_W];
    endfunction

endpackage

// File: rtl/cross_bar_slave_arbiter_if.sv
// ---------------------------------------------------------------------------
// cross_bar_slave_arbiter_if
// Bundles the master-facing and slave-facing signals of one slave arbiter.
//   Master side : master_req/addr/cmd/wdata (per master, in to arbiter),
//                 master_ack (one-hot), master_rdata, grant_idx, busy (out)
//   Slave side  : slave_req/addr/cmd/wdata (out), slave_ack/rdata (in)
// Modports:
//   slave  : the arbiter's view (it is the slave of the master requests)
//   master : the environment's view (masters plus the downstream slave)
// ---------------------------------------------------------------------------
interface cross_bar_slave_arbiter_if;
    import cross_bar_slave_arbiter_pkg::*;

    logic [MASTER_N-1:0] master_req;
    addr_t [MASTER_N-1:0] master_addr;
    logic [MASTER_N-1:0] master_cmd;
    data_t [MASTER_N-1:0] master_wdata;
    logic [MASTER_N-1:0] master_ack;
    data_t               master_rdata;
    midx_t               grant_idx;
    logic                busy;

    logic                slave_req;
    addr_t               slave_addr;
    logic                slave_cmd;
    data_t               slave_wdata;
    logic                slave_ack;
    data_t               slave_rdata;

    modport slave (
        input  master_req,
        input  master_addr,
        input  master_cmd,
        input  master_wdata,
        output master_ack,
        output master_rdata,
        output grant_idx,
        output busy,
        output slave_req,
        output slave_addr,
        output slave_cmd,
        output slave_wdata,
        input  slave_ack,
        input  slave_rdata
    );

    modport master (
        output master_req,
        output master_addr,
        output master_cmd,
        output master_wdata,
        input  master_ack,
        input  master_rdata,
        input  grant_idx,
        input  busy,
        input  slave_req,
        input  slave_addr,
        input  slave_cmd,
        input  slave_wdata,
        output slave_ack,
        output slave_rdata
    );

endinterface

// File: rtl/cross_bar_slave_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// cross_bar_slave_arbiter_rr_pick
// Combinational round-robin priority select.
//   elig   : in  MASTER_N  eligible masters
//   ptr    : in  MASTER_W  last served master
//   winner : out MASTER_W  first eligible master searching ptr+1, ptr+2, ...
//   valid  : out 1         any master eligible
// ---------------------------------------------------------------------------
module cross_bar_slave_arbiter_rr_pick
    import cross_bar_slave_arbiter_pkg::*;
(
    input  logic [MASTER_N-1:0] elig,
    input  midx_t               ptr,
    output midx_t               winner,
    output logic                valid
);

    midx_t idx;

    // Walk from the farthest offset down to the nearest so the last hit,
    // which is the one that sticks, is the closest master after ptr.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int off = MASTER_N; off >= 1; off--) begin
            idx = midx_t'((int'(ptr) + off) % MASTER_N);
            if (elig[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cross_bar_slave_arbiter.sv
// ---------------------------------------------------------------------------
// cross_bar_slave_arbiter
// Shares one slave port among MASTER_N masters. Masters whose address
// selects SLAVE_ID are arbitrated round-robin; the winner's transaction is
// forwarded to the slave with a 4-phase req/ack handshake and the slave's
// ack/rdata is returned to that master, again 4-phase. All outputs are
// registered.
//   clk     : in  clock, all logic on posedge
//   aresetn : in  synchronous active-low reset
//   bus     : cross_bar_slave_arbiter_if.slave
//             master_req/addr/cmd/wdata in, master_ack/rdata out,
//             grant_idx/busy out, slave_req/addr/cmd/wdata out,
//             slave_ack/rdata in
// ---------------------------------------------------------------------------
module cross_bar_slave_arbiter
    import cross_bar_slave_arbiter_pkg::*;
#(
    parameter int SLAVE_ID = 0
)
(
    input  logic                       clk,
    input  logic                       aresetn,
    cross_bar_slave_arbiter_if.slave   bus
);

    localparam sidx_t SEL = sidx_t'(SLAVE_ID);

    arb_state_t          state_q, state_d;
    midx_t               ptr_q, ptr_d;
    midx_t               grant_q, grant_d;
    logic                slave_req_q, slave_req_d;
    addr_t               slave_addr_q, slave_addr_d;
    logic                slave_cmd_q, slave_cmd_d;
    data_t               slave_wdata_q, slave_wdata_d;
    logic [MASTER_N-1:0] master_ack_q, master_ack_d;
    data_t               master_rdata_q, master_rdata_d;
    logic                busy_q, busy_d;

    logic [MASTER_N-1:0] elig;
    midx_t               pick_idx;
    logic                pick_valid;

    for (genvar m = 0; m < MASTER_N; m++) begin : g_elig
        assign elig[m] = bus.master_req[m] & (slave_sel(bus.master_addr[m]) == SEL);
    end

    cross_bar_slave_arbiter_rr_pick u_rr_pick (
        .elig   (elig),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        grant_d        = grant_q;
        slave_req_d    = slave_req_q;
        slave_addr_d   = slave_addr_q;
        slave_cmd_d    = slave_cmd_q;
        slave_wdata_d  = slave_wdata_q;
        master_ack_d   = master_ack_q;
        master_rdata_d = master_rdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                // Payload is latched even for reads so the slave bus never
                // changes while slave_req is high.
                if (pick_valid) begin
                    grant_d       = pick_idx;
                    slave_addr_d  = bus.master_addr[pick_idx];
                    slave_cmd_d   = bus.master_cmd[pick_idx];
                    slave_wdata_d = bus.master_wdata[pick_idx];
                    slave_req_d   = 1'b1;
                    state_d       = ARB_SREQ;
                end
            end
            ARB_SREQ: begin
                // The winner dropping its request here is a protocol error;
                // the transaction is completed regardless.
                if (bus.slave_ack) begin
                    master_rdata_d = bus.slave_rdata;
                    slave_req_d    = 1'b0;
                    master_ack_d   = onehot(grant_q);
                    state_d        = ARB_MACK;
                end
            end
            ARB_MACK: begin
                // Both handshakes must be fully released before the slave
                // can be offered to anyone else.
                if (!bus.master_req[grant_q] && !bus.slave_ack) begin
                    master_ack_d = '0;
                    ptr_d        = grant_q;
                    state_d      = ARB_IDLE;
                end
            end
            default: begin
                slave_req_d  = 1'b0;
                master_ack_d = '0;
                state_d      = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q        <= ARB_IDLE;
            ptr_q          <= midx_t'(MASTER_N - 1);
            grant_q        <= '0;
            slave_req_q    <= 1'b0;
            slave_addr_q   <= '0;
            slave_cmd_q    <= 1'b0;
            slave_wdata_q  <= '0;
            master_ack_q   <= '0;
            master_rdata_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_q        <= grant_d;
            slave_req_q    <= slave_req_d;
            slave_addr_q   <= slave_addr_d;
            slave_cmd_q    <= slave_cmd_d;
            slave_wdata_q  <= slave_wdata_d;
            master_ack_q   <= master_ack_d;
            master_rdata_q <= master_rdata_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.master_ack   = master_ack_q;
    assign bus.master_rdata = master_rdata_q;
    assign bus.grant_idx    = grant_q;
    assign bus.busy         = busy_q;
    assign bus.slave_req    = slave_req_q;
    assign bus.slave_addr   = slave_addr_q;
    assign bus.slave_cmd    = slave_cmd_q;
    assign bus.slave_wdata  = slave_wdata_q;

endmodule

// File: tb/tb_cross_bar_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cross_bar_slave_arbiter
// Bench for the SLAVE_ID=0 slave arbiter: drives masters, models the slave,
// and checks grants/payload/acks against a queue of expected transactions.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cross_bar_slave_arbiter;
    import cross_bar_slave_arbiter_pkg::*;

    typedef struct {
        midx_t m;
        addr_t addr;
        logic  cmd;
        data_t wdata;
        data_t rdata;
    } exp_t;

    localparam int OTHER_SLAVE = SLAVE_N - 3;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    cross_bar_slave_arbiter_if bif();

    cross_bar_slave_arbiter #(.SLAVE_ID(0)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bif)
    );

    int    checks = 0;
    int    failures = 0;
    exp_t  sb[$];
    bit    slave_en = 1'b1;
    int    slave_hold = 0;
    bit    rd_fixed_en = 1'b0;
    data_t rd_fixed = '0;

    function automatic data_t rd_of(input addr_t a);
        return {a[15:0], ~a[31:16]};
    endfunction

    // Slave model: acks one negedge after seeing slave_req, then keeps ack
    // high for slave_hold extra cycles after slave_req drops.
    initial begin
        int hold_left;
        hold_left = 0;
        bif.slave_ack   = 1'b0;
        bif.slave_rdata = '0;
        forever begin
            @(negedge clk);
            if (!bif.slave_ack) begin
                if (slave_en && bif.slave_req === 1'b1) begin
                    bif.slave_ack   = 1'b1;
                    bif.slave_rdata = rd_fixed_en ? rd_fixed : rd_of(bif.slave_addr);
                    hold_left       = slave_hold;
                end
            end else if (bif.slave_req !== 1'b1) begin
                if (hold_left == 0) bif.slave_ack = 1'b0;
                else hold_left--;
            end
        end
    end

    // Ack must be one-hot or zero and never overlap slave_req.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(bif.master_ack) || (bif.slave_req && (bif.master_ack != '0))) begin
            failures++;
            $display("FAIL invariant: master_ack=%b slave_req=%b, required one-hot-or-zero ack and no overlap",
                     bif.master_ack, bif.slave_req);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input midx_t m, input addr_t a, input logic c, input data_t w);
        exp_t e;
        bif.master_addr[m]  = a;
        bif.master_cmd[m]   = c;
        bif.master_wdata[m] = w;
        bif.master_req[m]   = 1'b1;
        e.m = m; e.addr = a; e.cmd = c; e.wdata = w;
        e.rdata = rd_fixed_en ? rd_fixed : rd_of(a);
        sb.push_back(e);
    endtask

    // Serves queued transactions in order: checks the slave-side payload when
    // slave_req appears, then the ack/rdata, then releases that master.
    task automatic drain(input string name, input int budget);
        int   cyc;
        bit   req_seen;
        exp_t e;
        cyc = 0;
        req_seen = 1'b0;
        while (sb.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bif.slave_req === 1'b1 && !req_seen) begin
                req_seen = 1'b1;
                checks++;
                if (bif.grant_idx !== sb[0].m || bif.slave_addr !== sb[0].addr ||
                    bif.slave_cmd !== sb[0].cmd || bif.slave_wdata !== sb[0].wdata) begin
                    failures++;
                    $display("FAIL %s issue: grant=%0d addr=%h cmd=%b wdata=%h, required grant=%0d addr=%h cmd=%b wdata=%h",
                             name, bif.grant_idx, bif.slave_addr, bif.slave_cmd, bif.slave_wdata,
                             sb[0].m, sb[0].addr, sb[0].cmd, sb[0].wdata);
                end
            end
            if (bif.master_ack !== '0) begin
                e = sb.pop_front();
                checks++;
                if (!req_seen || bif.master_ack !== onehot(e.m) || bif.master_rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL %s ack: ack=%b rdata=%h req_seen=%0d, required ack=%b rdata=%h req_seen=1",
                             name, bif.master_ack, bif.master_rdata, req_seen, onehot(e.m), e.rdata);
                end
                bif.master_req = bif.master_req & ~bif.master_ack;
                req_seen = 1'b0;
                while (bif.master_ack !== '0 && cyc < budget) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        checks++;
        if (sb.size() != 0 || bif.master_ack !== '0) begin
            failures++;
            $display("FAIL %s timeout: %0d transactions left, ack=%b, required 0 left and ack=0",
                     name, sb.size(), bif.master_ack);
            sb.delete();
            bif.master_req = '0;
        end
    endtask

    task automatic test_reset();
        bif.master_req   = '0;
        bif.master_addr  = '0;
        bif.master_cmd   = '0;
        bif.master_wdata = '0;
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bif.slave_req !== 1'b0 || bif.master_ack !== '0 || bif.busy !== 1'b0 || bif.grant_idx !== '0) begin
            failures++;
            $display("FAIL reset ctrl: slave_req=%b ack=%b busy=%b grant=%0d, required 0 0 0 0",
                     bif.slave_req, bif.master_ack, bif.busy, bif.grant_idx);
        end
        checks++;
        if (bif.slave_addr !== '0 || bif.slave_cmd !== 1'b0 || bif.slave_wdata !== '0 || bif.master_rdata !== '0) begin
            failures++;
            $display("FAIL reset data: addr=%h cmd=%b wdata=%h rdata=%h, required all 0",
                     bif.slave_addr, bif.slave_cmd, bif.slave_wdata, bif.master_rdata);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_single_write();
        exp_t e;
        @(negedge clk);
        drive_req(2'd0, 32'h0000_0010, 1'b1, 32'hdead_c0de);
        @(negedge clk);
        checks++;
        if (bif.slave_req !== 1'b1 || bif.slave_addr !== 32'h0000_0010 || bif.slave_cmd !== 1'b1 ||
            bif.slave_wdata !== 32'hdead_c0de || bif.busy !== 1'b1) begin
            failures++;
            $display("FAIL write issue: req=%b addr=%h cmd=%b wdata=%h busy=%b, required 1 00000010 1 deadc0de 1",
                     bif.slave_req, bif.slave_addr, bif.slave_cmd, bif.slave_wdata, bif.busy);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (bif.master_ack !== 4'b0001 || bif.slave_req !== 1'b0 || bif.master_rdata !== e.rdata) begin
            failures++;
            $display("FAIL write ack: ack=%b slave_req=%b rdata=%h, required 0001 0 %h",
                     bif.master_ack, bif.slave_req, bif.master_rdata, e.rdata);
        end
        bif.master_req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.master_ack !== '0 || bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL write release: ack=%b busy=%b, required 0000 0", bif.master_ack, bif.busy);
        end
    endtask

    task automatic test_read_m1();
        rd_fixed_en = 1'b1;
        rd_fixed    = 32'h0f0f_0f0f;
        @(negedge clk);
        drive_req(2'd1, 32'h0000_0004, 1'b0, 32'hcafe_f00d);
        drain("read_m1", 20);
        rd_fixed_en = 1'b0;
    endtask

    task automatic test_round_robin();
        test_reset();
        @(negedge clk);
        drive_req(2'd0, 32'h0000_0100, 1'b1, 32'h1111_0000);
        drive_req(2'd1, 32'h0000_0104, 1'b0, 32'h2222_0000);
        drive_req(2'd2, 32'h0000_0108, 1'b1, 32'h3333_0000);
        drain("rr_first", 60);
        @(negedge clk);
        drive_req(2'd3, 32'h0000_020c, 1'b0, 32'h4444_0000);
        drive_req(2'd0, 32'h0000_0200, 1'b0, 32'h5555_0000);
        drain("rr_wrap", 40);
    endtask

    task automatic test_wrong_slave();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        bif.master_addr[2] = {sidx_t'(OTHER_SLAVE), 30'h0};
        bif.master_cmd[2]  = 1'b1;
        bif.master_req[2]  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bif.slave_req !== 1'b0 || bif.busy !== 1'b0 || bif.master_ack !== '0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL wrong_slave: slave_req/busy/ack went active (now %b/%b/%b), required all 0",
                     bif.slave_req, bif.busy, bif.master_ack);
        end
        bif.master_req[2] = 1'b0;
    endtask

    task automatic test_reset_mid_sreq();
        slave_en = 1'b0;
        @(negedge clk);
        bif.master_addr[1]  = 32'h0000_0008;
        bif.master_cmd[1]   = 1'b1;
        bif.master_wdata[1] = 32'h7777_8888;
        bif.master_req[1]   = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.slave_req !== 1'b1 || bif.busy !== 1'b1 || bif.grant_idx !== 2'd1) begin
            failures++;
            $display("FAIL mid_sreq setup: slave_req=%b busy=%b grant=%0d, required 1 1 1",
                     bif.slave_req, bif.busy, bif.grant_idx);
        end
        aresetn = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.slave_req !== 1'b0 || bif.master_ack !== '0 || bif.busy !== 1'b0 || bif.grant_idx !== '0) begin
            failures++;
            $display("FAIL mid_sreq reset: slave_req=%b ack=%b busy=%b grant=%0d, required 0 0 0 0",
                     bif.slave_req, bif.master_ack, bif.busy, bif.grant_idx);
        end
        aresetn  = 1'b1;
        slave_en = 1'b1;
        drive_req(2'd0, 32'h0000_0000, 1'b0, 32'h9999_aaaa);
        drive_req(2'd1, 32'h0000_0008, 1'b1, 32'h7777_8888);
        drain("post_reset", 40);
    endtask

    task automatic test_long_slave_ack();
        exp_t e;
        bit   got;
        got = 1'b0;
        slave_hold = 5;
        @(negedge clk);
        drive_req(2'd1, 32'h0000_0020, 1'b0, 32'h0);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bif.master_ack !== '0) got = 1'b1;
        end
        e = sb.pop_front();
        checks++;
        if (!got || bif.master_ack !== onehot(e.m) || bif.master_rdata !== e.rdata) begin
            failures++;
            $display("FAIL hold ack: ack=%b rdata=%h, required %b %h", bif.master_ack, bif.master_rdata,
                     onehot(e.m), e.rdata);
        end
        bif.master_req[1] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (bif.master_ack !== 4'b0010) begin
                failures++;
                $display("FAIL hold cycle%0d: ack=%b, required 0010", i, bif.master_ack);
            end
        end
        @(negedge clk);
        checks++;
        if (bif.master_ack !== '0 || bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL hold release: ack=%b busy=%b, required 0000 0", bif.master_ack, bif.busy);
        end
        slave_hold = 0;
    endtask

    task automatic test_master_hold_ack();
        exp_t e;
        bit   got;
        got = 1'b0;
        @(negedge clk);
        drive_req(2'd2, 32'h0000_0030, 1'b1, 32'habcd_1234);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bif.master_ack !== '0) got = 1'b1;
        end
        e = sb.pop_front();
        checks++;
        if (!got || bif.master_ack !== 4'b0100 || bif.master_rdata !== e.rdata) begin
            failures++;
            $display("FAIL mhold ack: ack=%b rdata=%h, required 0100 %h", bif.master_ack, bif.master_rdata, e.rdata);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (bif.master_ack !== 4'b0100) begin
                failures++;
                $display("FAIL mhold cycle%0d: ack=%b, required 0100", i, bif.master_ack);
            end
        end
        bif.master_req[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.master_ack !== '0 || bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL mhold release: ack=%b busy=%b, required 0000 0", bif.master_ack, bif.busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_m1();
        test_round_robin();
        test_wrong_slave();
        test_reset_mid_sreq();
        test_long_slave_ack();
        test_master_hold_ack();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
